// File: rtl/l1_l2_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// l1_l2_arbiter_pkg
//   Shared cache package for the L1 -> L2 arbiter.
//   Contents:
//     LINE_WIDTH  - default cache line width in bits (256)
//     arb_state_e - arbiter FSM states (IDLE, SERVE_I, SERVE_D)
//     req_id_e    - requester identity (I-cache or D-cache)
//     l2_cmd_t    - latched L2 command (line address + operation)
// -----------------------------------------------------------------------------
package l1_l2_arbiter_pkg;

  localparam int unsigned LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
  } l2_cmd_t;

endpackage : l1_l2_arbiter_pkg

// File: rtl/rr_grant2.sv
// -----------------------------------------------------------------------------
// rr_grant2
//   Two-requester round-robin grant (purely combinational).
//   Ports:
//     req_i      in  I-cache request
//     req_d      in  D-cache request
//     last_grant in  requester granted most recently
//     gnt_valid  out at least one request is pending
//     gnt_id     out requester to grant (meaningful when gnt_valid)
// -----------------------------------------------------------------------------
module rr_grant2
  import l1_l2_arbiter_pkg::*;
(
  input  logic    req_i,
  input  logic    req_d,
  input  req_id_e last_grant,
  output logic    gnt_valid,
  output req_id_e gnt_id
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    gnt_valid = req_i | req_d;
    gnt_id    = REQ_I;
    if (req_i && req_d) begin
      // On a tie, the side that did not win last time goes next.
      gnt_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (req_d) begin
      gnt_id = REQ_D;
    end
  end

endmodule : rr_grant2

// File: rtl/l1_l2_arbiter.sv
// -----------------------------------------------------------------------------
// l1_l2_arbiter
//   Shares one L2 port between an I-cache and a D-cache. A request seen in
//   IDLE is granted (round-robin on ties, D first after reset), its address,
//   operation and write data are latched, and the L2 request is driven from
//   those registers until l2_resp, which is forwarded combinationally as the
//   granted side's one-cycle resp. At least one IDLE cycle separates grants.
//   Ports:
//     clk, rst                       clock, synchronous active-high reset
//     i_read, i_address              I-cache read request (held until i_resp)
//     i_rdata, i_resp                I-cache returned line / completion pulse
//     d_read, d_write, d_address,
//     d_wdata                        D-cache request (held until d_resp)
//     d_rdata, d_resp                D-cache returned line / completion pulse
//     l2_read, l2_write, l2_address,
//     l2_wdata                       request to L2
//     l2_rdata, l2_resp              L2 returned line / completion pulse
// -----------------------------------------------------------------------------
module l1_l2_arbiter
  import l1_l2_arbiter_pkg::*;
#(
  parameter int unsigned width = LINE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_read,
  input  logic [31:0]      i_address,
  output logic [width-1:0] i_rdata,
  output logic             i_resp,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [31:0]      d_address,
  input  logic [width-1:0] d_wdata,
  output logic [width-1:0] d_rdata,
  output logic             d_resp,
  output logic             l2_read,
  output logic             l2_write,
  output logic [31:0]      l2_address,
  output logic [width-1:0] l2_wdata,
  input  logic [width-1:0] l2_rdata,
  input  logic             l2_resp
);

  arb_state_e       state_q, state_d;
  req_id_e          last_q, last_d;
  l2_cmd_t          cmd_q, cmd_d;
  logic [width-1:0] wdata_q, wdata_d;

  logic    gnt_valid;
  req_id_e gnt_id;

  rr_grant2 u_rr_grant2 (
    .req_i      (i_read),
    .req_d      (d_read | d_write),
    .last_grant (last_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Read data is only meaningful in the cycle of the matching resp.
  assign i_rdata    = l2_rdata;
  assign d_rdata    = l2_rdata;
  // L2 address/data come solely from the latched command, so requesters may
  // change or drop their inputs once granted.
  assign l2_address = cmd_q.addr;
  assign l2_wdata   = wdata_q;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cmd_d    = cmd_q;
    wdata_d  = wdata_q;
    l2_read  = 1'b0;
    l2_write = 1'b0;
    i_resp   = 1'b0;
    d_resp   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // l2_resp is ignored here: no transaction is outstanding.
        if (gnt_valid) begin
          if (gnt_id == REQ_D) begin
            state_d     = SERVE_D;
            cmd_d.addr  = d_address;
            // Read and write together is treated as a write.
            cmd_d.write = d_write;
            wdata_d     = d_wdata;
          end else begin
            state_d     = SERVE_I;
            cmd_d.addr  = i_address;
            cmd_d.write = 1'b0;
          end
        end
      end

      SERVE_I: begin
        l2_read = 1'b1;
        if (l2_resp) begin
          i_resp  = 1'b1;
          last_d  = REQ_I;
          state_d = IDLE;
        end
      end

      SERVE_D: begin
        l2_read  = ~cmd_q.write;
        l2_write = cmd_q.write;
        if (l2_resp) begin
          d_resp  = 1'b1;
          last_d  = REQ_D;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      last_q  <= REQ_I;   // D wins the first tie after reset
      cmd_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
    end
  end

endmodule : l1_l2_arbiter

// File: doc/l1_l2_arbiter.md
L1_L2_ARBITER -- requirements
Module: l1_l2_arbiter

Interface
REQ-001 SHALL have parameter: width, 256, cache line width in bits for all data buses.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: i_read  input  1  I-cache line read request, held until i_resp.
REQ-005 SHALL have port: i_address  input  32  I-cache line address.
REQ-006 SHALL have ports: i_rdata output width returned line; i_resp output 1 one-cycle completion pulse.
REQ-007 SHALL have ports: d_read input 1, d_write input 1, d_address input 32, d_wdata input width; all held until d_resp.
REQ-008 SHALL have ports: d_rdata output width returned line; d_resp output 1 one-cycle completion pulse.
REQ-009 SHALL have ports: l2_read output 1, l2_write output 1, l2_address output 32, l2_wdata output width.
REQ-010 SHALL have ports: l2_rdata input width, l2_resp input 1 one-cycle completion pulse from L2.

Function
REQ-011 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-012 IDLE SHALL drive l2_read=0, l2_write=0, i_resp=0, d_resp=0.
REQ-013 IDLE with only i_read SHALL go to SERVE_I next cycle; with only d_read or d_write SHALL go to SERVE_D.
REQ-014 IDLE with both pending SHALL grant the requester not granted last (round-robin); first tie after reset SHALL go to D.
REQ-015 On the IDLE->SERVE transition the block SHALL latch address, operation and (D only) wdata into registers.
REQ-016 In SERVE_x, l2_address, l2_wdata, l2_read, l2_write SHALL come only from the latched registers, stable until l2_resp.
REQ-017 d_read and d_write both asserted SHALL be treated as a write.
REQ-018 SERVE_I SHALL drive l2_read=1, l2_write=0; SERVE_D SHALL drive l2_read/l2_write per the latched operation.
REQ-019 In SERVE_x, l2_resp SHALL assert the granted requester's resp combinationally in the same cycle; the non-granted resp SHALL stay 0.
REQ-020 i_rdata and d_rdata SHALL pass l2_rdata combinationally; they are valid only in the cycle of their resp.
REQ-021 On l2_resp the FSM SHALL return to IDLE and update the last-granted flag.
REQ-022 The FSM SHALL spend at least one cycle in IDLE between grants so requesters can drop their request after resp.
REQ-023 Latency SHALL be: request seen in IDLE at cycle N -> L2 request visible at N+1 -> resp in the same cycle as l2_resp.
REQ-024 A request deasserted while in SERVE_x SHALL NOT cancel the L2 transaction; the transaction runs to l2_resp.
REQ-025 l2_resp in IDLE SHALL be ignored.

Reset
REQ-026 rst SHALL force IDLE, clear the latched address/wdata/operation, and set the last-granted flag to I (so D wins the first tie).
REQ-027 rst during SERVE_x SHALL abandon the transaction; the next cycle SHALL show IDLE outputs, with no resp pulse.

Structure
REQ-028 The FSM state enum and the requester-id type SHALL be in the shared cache package, together with the default line width 256.
REQ-029 No sub-module is required; the round-robin grant logic MAY be a sub-module named rr_grant2.

Verification
REQ-030 After reset, i_read=1 at address 0x0000_1000, L2 responds 3 cycles later -> l2_read=1 with l2_address=0x1000 for 3 cycles, then a single i_resp pulse with i_rdata=l2_rdata.
REQ-031 After reset, i_read and d_write rise in the same cycle -> D granted first (l2_write=1, d_wdata passed to L2), then after one IDLE cycle I granted.
REQ-032 Both requesters held continuously for 4 transactions -> grant order D, I, D, I, with exactly one IDLE cycle between grants.
REQ-033 d_address is changed mid-SERVE_D from 0x2000 to 0x3000 -> l2_address stays 0x2000 until l2_resp.
REQ-034 rst is pulsed in SERVE_D -> no d_resp pulse, l2_read=l2_write=0 in the next cycle, and an i_read alone is granted afterwards.
REQ-035 d_read=d_write=1 -> l2_write=1 and l2_read=0; l2_resp pulsed in IDLE -> no resp outputs and the state is unchanged.
